uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the single UART transmitter.
REQ-002 Parameter SETTLE_CYC, default 16, clk cycles to wait after a baud change before starting transmission.
REQ-003 Parameter TIMEOUT_CYC, default 200000, maximum clk cycles allowed in WAIT before aborting.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester request level.
REQ-007 req_data  in  NREQ*8  byte per requester; slice i = bits [8i+7:8i].
REQ-008 req_baud  in  NREQ*17  baud rate per requester; slice i = bits [17i+16:17i].
REQ-009 gnt  out  NREQ  one-hot grant, held for the whole transaction.
REQ-010 done  out  NREQ  one-cycle pulse to the granted requester on successful completion.
REQ-011 err  out  NREQ  one-cycle pulse to the granted requester on timeout.
REQ-012 baud  out  17  baud select driven to the clock generator.
REQ-013 tx_start  out  1  one-cycle start strobe to the transmitter.
REQ-014 tx_data  out  8  latched byte presented to the transmitter.
REQ-015 tx_busy  in  1  transmitter is busy; start is blocked while high.
REQ-016 tx_done  in  1  one-cycle pulse from the transmitter at frame end.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be exactly IDLE, CFG, START, WAIT and DONE.
REQ-019 IDLE with any req bit high: grant the first set bit searching upward from last_gnt+1, wrapping modulo NREQ; latch data and baud; set gnt and busy on the same edge.
REQ-020 Valid baud values: 4800, 9600, 14400, 19200, 38400, 57600, 115200 and 128000; any other latched value SHALL be substituted with 9600 before comparison and output.
REQ-021 Latched (substituted) baud equal to the current baud output: IDLE->START; otherwise update baud on the grant edge and go IDLE->CFG.
REQ-022 CFG: remain exactly SETTLE_CYC cycles, then go to START; baud stays stable.
REQ-023 START: tx_start = 1 combinationally while tx_busy = 0, and the FSM moves to WAIT on that same edge; while tx_busy = 1, remain in START with tx_start = 0.
REQ-024 tx_start SHALL never be high for more than one consecutive cycle per transaction.
REQ-025 WAIT: tx_done -> DONE; the timeout counter reaching TIMEOUT_CYC cycles in WAIT -> pulse err[g] for one cycle, clear gnt, go to IDLE.
REQ-026 tx_done and timeout expiry in the same cycle: tx_done SHALL win; no err pulse.
REQ-027 DONE (one cycle): done[g] = 1, gnt cleared at the exit edge, last_gnt = g, next state IDLE.
REQ-028 Timeout abort SHALL also set last_gnt = g.
REQ-029 Latency, req seen in IDLE at cycle n, same baud: gnt and tx_start first high in cycle n+1 (tx_busy = 0).
REQ-030 Latency, req seen in IDLE at cycle n, different baud: baud changes in cycle n+1; tx_start in cycle n+SETTLE_CYC+1.
REQ-031 req deasserted mid-transaction SHALL be ignored; the transaction completes normally.
REQ-032 req still high after done or err counts as a new request, arbitrated fairly in IDLE.
REQ-033 tx_done outside WAIT SHALL be ignored.
REQ-034 tx_data and gnt SHALL remain stable from the grant edge until DONE or abort.
REQ-035 Timeout and settle counters SHALL be wide enough for their parameters and clear on every state entry.

Reset
REQ-036 On rst: state IDLE; gnt, done, err, tx_start and busy = 0; tx_data = 0; baud = 9600; counters 0; last_gnt = NREQ-1, so requester 0 has first priority.
REQ-037 rst asserted mid-transaction SHALL abort immediately with no done or err pulse; tx_start low in the following cycle.

Verification
REQ-038 After reset, req = 4'b0001, req_baud[0] = 9600, tx_busy = 0 -> gnt = 0001 and tx_start pulse in the next cycle, no baud change; tx_done 10 cycles later -> done[0] pulse, gnt = 0.
REQ-039 req_baud[1] = 115200, current baud = 9600 -> baud = 115200 one cycle after req; tx_start exactly 16 cycles later; tx_data = req_data[1].
REQ-040 req = 4'b1111 held, each transfer completed -> grant order 0, 1, 2, 3, 0; no requester granted twice in a row.
REQ-041 tx_done never arrives -> err[g] pulse after 200000 WAIT cycles, gnt = 0, FSM in IDLE; the next requester is served after that.
REQ-042 tx_busy = 1 during START for 5 cycles -> tx_start held low, then one pulse when tx_busy falls; tx_done coincident with the timeout cycle -> done, no err.
REQ-043 req_baud = 12345 -> baud output 9600; rst pulsed while in WAIT -> all outputs return to their reset values in the next cycle.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmitter with per-requester baud and data.
module uart_tx_scheduler #(
  parameter int NREQ = 4,
  parameter int SETTLE_CYC = 16,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ*17-1:0] req_baud,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [16:0]       baud,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              busy
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CMAX = SETTLE_CYC > TIMEOUT_CYC ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, CFG, START, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] last_gnt, cur, pick, pick_lo, pick_hi;
  logic [7:0] sel_data;
  logic [16:0] raw_baud, sel_baud;
  logic found_hi, settled, expired;
  // Two-pass search: lowest requester above last_gnt, else lowest overall.
  always_comb begin
    pick_lo = '0;
    pick_hi = '0;
    found_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) pick_lo = IW'(i);
      if (req[i] && i > int'(last_gnt)) begin
        pick_hi = IW'(i);
        found_hi = 1'b1;
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
    sel_data = '0;
    raw_baud = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        sel_data = req_data[8*i +: 8];
        raw_baud = req_baud[17*i +: 17];
      end
    end
    sel_baud = raw_baud inside {17'd4800, 17'd9600, 17'd14400, 17'd19200,
                                17'd38400, 17'd57600, 17'd115200, 17'd128000} ? raw_baud : 17'd9600;
  end
  assign settled = cnt == CW'(SETTLE_CYC - 1);
  assign expired = cnt == CW'(TIMEOUT_CYC - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |req ? (sel_baud == baud ? START : CFG) : IDLE;
      CFG:     state_n = settled ? START : CFG;
      START:   state_n = tx_busy ? START : WAIT;
      WAIT:    state_n = tx_done ? DONE : (expired ? IDLE : WAIT);
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign tx_start = state == START && !tx_busy;
  assign done = state == DONE ? gnt : '0;
  assign err = state == WAIT && expired && !tx_done ? gnt : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      gnt <= '0;
      cur <= '0;
      last_gnt <= IW'(NREQ - 1);
      tx_data <= '0;
      baud <= 17'd9600;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      if (state == IDLE && |req) begin
        gnt <= NREQ'(1) << pick;
        cur <= pick;
        tx_data <= sel_data;
        baud <= sel_baud;
      end
      if (state != IDLE && state_n == IDLE) begin
        gnt <= '0;
        last_gnt <= cur;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and random stimulus checked against a timestamp-based transaction model.
module tb_uart_tx_scheduler;
  localparam int N = 4;
  localparam int S = 16;
  localparam int T = 300;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N*17-1:0] req_baud = '0;
  logic [N-1:0] gnt, done, err;
  logic [16:0] baud;
  logic tx_start, busy;
  logic [7:0] tx_data;
  logic tx_busy = 1'b0;
  logic tx_done = 1'b0;
  int checks = 0;
  int failures = 0;
  int vb[8] = '{4800, 9600, 14400, 19200, 38400, 57600, 115200, 128000};

  uart_tx_scheduler #(.NREQ(N), .SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_baud(req_baud),
    .gnt(gnt), .done(done), .err(err), .baud(baud), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] subst(input logic [16:0] b);
    subst = 17'd9600;
    foreach (vb[i]) if (b == 17'(vb[i])) subst = b;
  endfunction

  // Transaction model: one active grant described by timestamps, not states.
  bit active = 0, started = 0, mvalid = 0, found;
  int cyc = 0, g = 0, last = N - 1, ready = 0, scyc = 0, dcyc = -1;
  logic [16:0] m_baud = 17'd9600, sb;
  logic [7:0] m_data = '0;
  logic [N-1:0] eg, ed, ee;
  logic es;

  always @(negedge clk) begin
    eg = active ? N'(1 << g) : '0;
    ed = '0;
    ee = '0;
    es = 1'b0;
    if (active) begin
      if (dcyc == cyc) ed = N'(1 << g);
      else if (!started) es = cyc >= ready && !tx_busy;
      else if (!tx_done && cyc - scyc == T) ee = N'(1 << g);
    end
    if (mvalid) begin
      chk("gnt", 32'(gnt), 32'(eg));
      chk("busy", 32'(busy), 32'(active));
      chk("done", 32'(done), 32'(ed));
      chk("err", 32'(err), 32'(ee));
      chk("tx_start", 32'(tx_start), 32'(es));
      chk("baud", 32'(baud), 32'(m_baud));
      chk("tx_data", 32'(tx_data), 32'(m_data));
    end
    if (rst) begin
      active = 0;
      m_baud = 17'd9600;
      m_data = '0;
      last = N - 1;
      dcyc = -1;
      mvalid = 1;
    end else if (mvalid) begin
      if (active) begin
        if (ed != 0 || ee != 0) begin
          active = 0;
          last = g;
        end else if (es) begin
          started = 1;
          scyc = cyc;
        end else if (started && tx_done) dcyc = cyc + 1;
      end else if (req != 0) begin
        found = 0;
        for (int k = 1; k <= N; k++)
          if (!found && req[(last + k) % N]) begin
            found = 1;
            g = (last + k) % N;
          end
        sb = subst(req_baud[17*g +: 17]);
        active = 1;
        started = 0;
        dcyc = -1;
        ready = sb == m_baud ? cyc + 1 : cyc + 1 + S;
        m_baud = sb;
        m_data = req_data[8*g +: 8];
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_data = 32'($urandom);
    for (int i = 0; i < N; i++) req_baud[17*i +: 17] = 17'd9600;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_baud", 32'(baud), 32'd9600);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    // Same baud: grant and start one cycle after the request.
    req = 4'b0001;
    step();
    chk("a_gnt", 32'(gnt), 32'h1);
    chk("a_tx_start", 32'(tx_start), 32'd1);
    chk("a_baud", 32'(baud), 32'd9600);
    req = '0;
    repeat (10) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("a_done", 32'(done), 32'h1);
    step();
    chk("a_gnt_clr", 32'(gnt), 32'd0);
    // Baud change: settle before start.
    req_data[15:8] = 8'hA5;
    req_baud[17 +: 17] = 17'd115200;
    req = 4'b0010;
    step();
    chk("b_baud", 32'(baud), 32'd115200);
    chk("b_gnt", 32'(gnt), 32'h2);
    req = '0;
    repeat (15) step();
    chk("b_no_start", 32'(tx_start), 32'd0);
    step();
    chk("b_start", 32'(tx_start), 32'd1);
    chk("b_data", 32'(tx_data), 32'hA5);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    // Round robin from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_baud[17 +: 17] = 17'd9600;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("c_order", 32'(gnt), 32'(1 << (k % 4)));
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
    end
    // Timeout abort.
    req = 4'b0001;
    step();
    chk("d_gnt", 32'(gnt), 32'h1);
    repeat (T) step();
    chk("d_err", 32'(err), 32'h1);
    step();
    chk("d_gnt_clr", 32'(gnt), 32'd0);
    chk("d_idle", 32'(busy), 32'd0);
    req = 4'b1111;
    step();
    chk("d_next", 32'(gnt), 32'h2);
    req = '0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    // Start blocked by tx_busy, then tx_done on the timeout cycle.
    req = 4'b0100;
    tx_busy = 1'b1;
    step();
    chk("e_blocked", 32'(tx_start), 32'd0);
    repeat (4) step();
    chk("e_blocked5", 32'(tx_start), 32'd0);
    tx_busy = 1'b0;
    #1;
    chk("e_start", 32'(tx_start), 32'd1);
    req = '0;
    step();
    repeat (T - 1) step();
    tx_done = 1'b1;
    #1;
    chk("e_no_err", 32'(err), 32'd0);
    step();
    tx_done = 1'b0;
    chk("e_done", 32'(done), 32'h4);
    step();
    // Invalid baud substitution, then reset during WAIT.
    req_baud[51 +: 17] = 17'd12345;
    req = 4'b1000;
    step();
    chk("f_gnt", 32'(gnt), 32'h8);
    chk("f_baud", 32'(baud), 32'd9600);
    req = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("f_rst_gnt", 32'(gnt), 32'd0);
    chk("f_rst_busy", 32'(busy), 32'd0);
    chk("f_rst_start", 32'(tx_start), 32'd0);
    chk("f_rst_data", 32'(tx_data), 32'd0);
    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 7) == 0) req_data = 32'($urandom);
      if ($urandom_range(0, 15) == 0)
        for (int i = 0; i < N; i++)
          req_baud[17*i +: 17] = $urandom_range(0, 3) != 0 ? 17'(vb[$urandom_range(0, 7)])
                                                           : 17'($urandom_range(0, 131071));
      tx_busy = $urandom_range(0, 3) == 0;
      tx_done = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 499) == 0;
      step();
    end
    rst = 1'b0;
    tx_done = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
